// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end for a RAM; 10-bit command frames in, 8-bit read data out.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    typedef enum logic [2:0] {SHIFT, PULSE, WAIT, OUT, DONE} phase_t;

    state_t     state, state_next;
    phase_t     phase;
    logic [3:0] cnt;
    logic [8:0] shift;
    logic [7:0] rd_byte;
    logic       rd_addr_flag;
    logic       busy;

    assign busy = state inside {WRITE, READ_ADD, READ_DATA};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state != IDLE && ss_n)
            state_next = IDLE;
        else if (state == IDLE)
            state_next = ss_n ? IDLE : CHK_CMD;
        else if (state == CHK_CMD)
            state_next = !mosi ? WRITE : (rd_addr_flag ? READ_DATA : READ_ADD);
    end

    // The PULSE phase keeps the rx_valid cycle out of the tx_valid wait window.
    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        if (rst) begin
            phase        <= SHIFT;
            cnt          <= 4'd0;
            shift        <= 9'd0;
            rd_byte      <= 8'h00;
            rd_addr_flag <= 1'b0;
            rx_data      <= 10'h000;
            miso         <= 1'b0;
        end else if (ss_n) begin
            phase <= SHIFT;
            cnt   <= 4'd0;
            miso  <= 1'b0;
        end else if (state == CHK_CMD) begin
            shift <= {shift[7:0], mosi};
            cnt   <= 4'd0;
            phase <= SHIFT;
        end else if (busy) begin
            case (phase)
                SHIFT: begin
                    shift <= {shift[7:0], mosi};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd8) begin
                        rx_data  <= {shift, mosi};
                        rx_valid <= 1'b1;
                        phase    <= (state == READ_DATA) ? PULSE : DONE;
                        if (state == READ_ADD) rd_addr_flag <= 1'b1;
                    end
                end
                PULSE: phase <= WAIT;
                WAIT: begin
                    if (tx_valid) begin
                        rd_byte <= {tx_data[6:0], 1'b0};
                        miso    <= tx_data[7];
                        cnt     <= 4'd0;
                        phase   <= OUT;
                    end
                end
                OUT: begin
                    miso    <= rd_byte[7];
                    rd_byte <= {rd_byte[6:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        miso         <= 1'b0;
                        rd_addr_flag <= 1'b0;
                        phase        <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have no parameters; frame width is fixed at 10 bits in and 8 bits out.
REQ-002 clk  input  1  single clock; SPI serial clock, all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 ss_n  input  1  active-low slave select from the SPI master.
REQ-005 mosi  input  1  serial data from master, MSB first, sampled on posedge clk.
REQ-006 miso  output  1  serial data to master, MSB first, registered.
REQ-007 rx_data  output  10  received frame to the RAM: [9:8] command, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM.
REQ-010 tx_valid  input  1  qualifies tx_data; may stay high for many cycles.

Function
REQ-011 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, encoded in a registered state variable.
REQ-012 IDLE: ss_n=0 sampled -> CHK_CMD next cycle; otherwise stay.
REQ-013 CHK_CMD: capture mosi as frame bit 9; mosi=0 -> WRITE; mosi=1 and rd_addr_flag=0 -> READ_ADD; mosi=1 and rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: shift in frame bits 8..0 on the next 9 consecutive cycles, MSB first, using a 4-bit bit counter.
REQ-015 The cycle after bit 0 is captured, rx_data SHALL present the full 10-bit frame and rx_valid SHALL be 1 for exactly one cycle.
REQ-016 rx_data SHALL hold its last value until the next completed frame; command bits are forwarded unmodified, with no checking against the chosen state.
REQ-017 rd_addr_flag SHALL be set when a READ_ADD frame completes and cleared when a READ_DATA frame finishes shifting out all 8 miso bits.
REQ-018 In READ_DATA after rx_valid: wait for tx_valid=1, latch tx_data once, then drive miso with bits 7..0 on 8 consecutive cycles starting the cycle after the latch.
REQ-019 tx_valid SHALL be ignored in all states and phases other than the READ_DATA wait phase.
REQ-020 miso SHALL be 0 whenever it is not driving a read-data bit.
REQ-021 After a frame completes, including all miso bits for READ_DATA, the FSM SHALL remain in its state, ignoring mosi, until ss_n=1, then go to IDLE.
REQ-022 ss_n=1 in any non-IDLE state SHALL force IDLE next cycle.
    - Partial frame discarded, no rx_valid.
    - miso forced to 0.
    - rd_addr_flag unchanged.
REQ-023 ss_n=1 on the same cycle bit 0 is sampled SHALL abort the frame; no rx_valid.

Reset
REQ-024 rst=1 SHALL set the following on the next posedge, overriding all other inputs.
    - state=IDLE.
    - rd_addr_flag=0, bit counter=0.
    - rx_data=10'h000, rx_valid=0, miso=0, latched read byte=8'h00.
REQ-025 Reset asserted mid-frame or mid-readout SHALL discard the transfer with no rx_valid pulse.

Verification
REQ-026 Write address: ss_n low, mosi 00_0000_0101 -> rx_valid one cycle, rx_data=10'h005; state WRITE until ss_n high.
REQ-027 Write data: mosi 01_1010_1010 -> rx_data=10'h1AA, one rx_valid pulse.
REQ-028 Read sequence, steps run in order:
    - Frame 10_0000_0101 -> READ_ADD, rx_data=10'h205, flag=1.
    - Next frame 11_xxxx_xxxx -> READ_DATA, rx_data=10'h3xx.
    - tx_valid=1 with tx_data=8'hC3 -> miso 1,1,0,0,0,0,1,1 on 8 consecutive cycles, flag=0.
REQ-029 Abort: ss_n rises after 5 frame bits -> IDLE next cycle, no rx_valid; the following full frame is received correctly.
REQ-030 Reset mid-readout: rst=1 during miso bit 3 -> miso=0, state IDLE, flag=0; the next frame with bit9=1 enters READ_ADD.
REQ-031 tx_valid held high during a WRITE frame -> no miso activity, miso stays 0.
